truth_table_sweeper: RTL and testbench

- Sequential sweep-and-capture stage for the lab's small combinational blocks, such as the 3-input single-output exercise modules.
- Upstream role: drives every input combination onto the combinational block under test.
- Downstream role: samples the block's single output and assembles a 2**N_IN-bit truth table.
- Compares the captured table against a parameterised expected table and reports done/match through a start/done handshake.
- Replaces hand-written exhaustive stimulus with one reusable, synthesizable sequencer.

---
 rtl/truth_table_sweeper_if.sv | 51 +++++
 rtl/truth_table_sweeper.sv | 107 ++++++++++
 tb/tb_truth_table_sweeper.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the truth-table sweeper and its controller / block under test.
// With MISMATCH_LOG_EN defined, the bundle also carries first_bad and bad_valid.
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
) ();
  localparam int NV = 1 << N_IN;

  // Handshake: start is a level request that is sampled only while the sweeper
  // is idle (no queuing). busy is high from the accepting edge until the result
  // edge. done is a single-cycle pulse. table_out and match stay valid from done
  // until the next accepted start.
  logic            start;
  logic [N_IN-1:0] abc;
  logic            f_in;
  logic            busy;
  logic            done;
  logic [NV-1:0]   table_out;
  logic            match;
`ifdef MISMATCH_LOG_EN
  logic [N_IN-1:0] first_bad;
  logic            bad_valid;
`endif

  modport master (
    output start,
    output f_in,
    input  abc,
    input  busy,
    input  done,
    input  table_out,
`ifdef MISMATCH_LOG_EN
    input  first_bad,
    input  bad_valid,
`endif
    input  match
  );

  modport slave (
    input  start,
    input  f_in,
    output abc,
    output busy,
    output done,
    output table_out,
`ifdef MISMATCH_LOG_EN
    output first_bad,
    output bad_valid,
`endif
    output match
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives every input vector onto a small combinational block, captures its output
// as a truth table and compares it to EXPECTED. Optional macro: MISMATCH_LOG_EN.
module truth_table_sweeper #(
  parameter int                     N_IN     = 3,
  parameter int                     SETTLE   = 1,
  parameter logic [(1<<N_IN)-1:0]   EXPECTED = 8'hE8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.slave  sif,
  output logic [1:0]            state_dbg
);
  localparam int NV = 1 << N_IN;
  localparam int SW = $clog2(SETTLE + 1);
  localparam logic [N_IN-1:0] VEC_LAST    = N_IN'(NV - 1);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t          state;
  logic [N_IN-1:0] vec;
  logic [SW-1:0]   settle_cnt;
  logic [NV-1:0]   tbl_next;

  assign state_dbg = state;

  // Table as it will look after the current sample; match is computed from this
  // so the final bit is included at the same edge it is written.
  always_comb begin
    tbl_next      = sif.table_out;
    tbl_next[vec] = sif.f_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      vec           <= '0;
      settle_cnt    <= '0;
      sif.abc       <= '0;
      sif.busy      <= 1'b0;
      sif.done      <= 1'b0;
      sif.table_out <= '0;
      sif.match     <= 1'b0;
`ifdef MISMATCH_LOG_EN
      sif.first_bad <= '0;
      sif.bad_valid <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (sif.start) begin
            vec           <= '0;
            settle_cnt    <= '0;
            sif.abc       <= '0;
            sif.table_out <= '0;
            sif.match     <= 1'b0;
            sif.busy      <= 1'b1;
`ifdef MISMATCH_LOG_EN
            sif.first_bad <= '0;
            sif.bad_valid <= 1'b0;
`endif
            state         <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        S_SAMPLE: begin
          sif.table_out <= tbl_next;
`ifdef MISMATCH_LOG_EN
          if (!sif.bad_valid && (sif.f_in != EXPECTED[vec])) begin
            sif.first_bad <= vec;
            sif.bad_valid <= 1'b1;
          end
`endif
          // Terminal compare precedes the increment, so vec never wraps.
          if (vec == VEC_LAST) begin
            sif.match <= (tbl_next == EXPECTED);
            sif.busy  <= 1'b0;
            sif.done  <= 1'b1;
            sif.abc   <= '0;
            state     <= S_DONE;
          end else begin
            vec     <= vec + 1'b1;
            sif.abc <= vec + 1'b1;
            state   <= S_WAIT;
          end
        end
        S_DONE: begin
          sif.done <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: two instances (SETTLE=1 with a selectable
// model, SETTLE=3 with f_in tied high), hand-computed tables and timing.
module tb_truth_table_sweeper;
  logic clk;
  logic rst_n;
  int   checks;
  int   failures;
  int   model_sel;  // 0 = majority, 1 = xor
  logic [1:0] state_a;
  logic [1:0] state_b;

  truth_table_sweeper_if #(.N_IN(3)) ifa ();
  truth_table_sweeper_if #(.N_IN(3)) ifb ();

  truth_table_sweeper #(.N_IN(3), .SETTLE(1), .EXPECTED(8'hE8)) dut_a (
    .clk(clk), .rst_n(rst_n), .sif(ifa), .state_dbg(state_a)
  );
  truth_table_sweeper #(.N_IN(3), .SETTLE(3), .EXPECTED(8'hE8)) dut_b (
    .clk(clk), .rst_n(rst_n), .sif(ifb), .state_dbg(state_b)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Block-under-test models
  assign ifa.f_in = (model_sel == 0)
    ? ((ifa.abc[2] & ifa.abc[1]) | (ifa.abc[1] & ifa.abc[0]) | (ifa.abc[2] & ifa.abc[0]))
    : (ifa.abc[2] ^ ifa.abc[1] ^ ifa.abc[0]);
  assign ifb.f_in = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full sweep on instance A with start pulsed at E0 (and optionally re-pulsed
  // at E5 and E9, which must be ignored).
  task automatic sweep_a(input logic [7:0] exp_tbl, input logic exp_match,
                         input bit repulse, input string tag);
    ifa.start = 1'b1;
    tick();  // E0
    ifa.start = 1'b0;
    check({tag, "_busy_start"}, 32'(ifa.busy), 32'd1);
    for (int e = 1; e <= 16; e++) begin
      check({tag, "_abc"}, 32'(ifa.abc), 32'((e - 1) / 2));
      check({tag, "_done_early"}, 32'(ifa.done), 32'd0);
      if (repulse && (e == 5 || e == 9)) ifa.start = 1'b1;
      tick();
      ifa.start = 1'b0;
    end
    check({tag, "_done"}, 32'(ifa.done), 32'd1);
    check({tag, "_busy_done"}, 32'(ifa.busy), 32'd0);
    check({tag, "_table"}, 32'(ifa.table_out), 32'(exp_tbl));
    check({tag, "_match"}, 32'(ifa.match), 32'(exp_match));
    check({tag, "_abc_done"}, 32'(ifa.abc), 32'd0);
    tick();
    check({tag, "_done_drop"}, 32'(ifa.done), 32'd0);
    check({tag, "_state_idle"}, 32'(state_a), 32'd0);
    check({tag, "_table_hold"}, 32'(ifa.table_out), 32'(exp_tbl));
    check({tag, "_match_hold"}, 32'(ifa.match), 32'(exp_match));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    model_sel = 0;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    rst_n     = 1'b0;
    #12;
    check("rst_abc", 32'(ifa.abc), 32'd0);
    check("rst_busy", 32'(ifa.busy), 32'd0);
    check("rst_done", 32'(ifa.done), 32'd0);
    check("rst_table", 32'(ifa.table_out), 32'd0);
    check("rst_match", 32'(ifa.match), 32'd0);
    check("rst_state", 32'(state_a), 32'd0);
    rst_n = 1'b1;
    tick();
    tick();
    check("idle_no_start", 32'(ifa.busy), 32'd0);

    // Majority model: table E8, match
    model_sel = 0;
    sweep_a(8'hE8, 1'b1, 1'b0, "maj");
`ifdef MISMATCH_LOG_EN
    check("maj_bad_valid", 32'(ifa.bad_valid), 32'd0);
`endif

    // XOR model: table 96, no match, first mismatch at vector 1
    model_sel = 1;
    sweep_a(8'h96, 1'b0, 1'b0, "xor");
`ifdef MISMATCH_LOG_EN
    check("xor_first_bad", 32'(ifa.first_bad), 32'd1);
    check("xor_bad_valid", 32'(ifa.bad_valid), 32'd1);
`endif

    // start re-pulsed mid-sweep is ignored
    model_sel = 0;
    sweep_a(8'hE8, 1'b1, 1'b1, "repulse");

    // SETTLE=3, f_in tied high: 4 cycles per vector, done after E32
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      check("b_abc", 32'(ifb.abc), 32'((e - 1) / 4));
      check("b_done_early", 32'(ifb.done), 32'd0);
      tick();
    end
    check("b_done", 32'(ifb.done), 32'd1);
    check("b_table", 32'(ifb.table_out), 32'hFF);
    check("b_match", 32'(ifb.match), 32'd0);
    tick();
    check("b_done_drop", 32'(ifb.done), 32'd0);

    // Reset mid-sweep while abc=4
    model_sel = 0;
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    begin
      int n;
      n = 0;
      while (ifa.abc !== 3'd4 && n < 20) begin
        tick();
        n++;
      end
      check("rst_mid_reach_abc4", 32'(ifa.abc), 32'd4);
    end
    rst_n = 1'b0;
    #1;
    check("rstmid_abc", 32'(ifa.abc), 32'd0);
    check("rstmid_busy", 32'(ifa.busy), 32'd0);
    check("rstmid_table", 32'(ifa.table_out), 32'd0);
    check("rstmid_match", 32'(ifa.match), 32'd0);
    check("rstmid_state", 32'(state_a), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    sweep_a(8'hE8, 1'b1, 1'b0, "after_rst");

    // start held high: back-to-back sweeps with a 1-cycle IDLE gap
    ifa.start = 1'b1;
    tick();  // E0 accept
    for (int e = 1; e <= 16; e++) tick();
    check("b2b_done1", 32'(ifa.done), 32'd1);
    check("b2b_table1", 32'(ifa.table_out), 32'hE8);
    tick();  // DONE -> IDLE
    check("b2b_gap_idle", 32'(state_a), 32'd0);
    check("b2b_gap_busy", 32'(ifa.busy), 32'd0);
    tick();  // second accept edge
    check("b2b_accept_busy", 32'(ifa.busy), 32'd1);
    check("b2b_accept_table", 32'(ifa.table_out), 32'd0);
    check("b2b_accept_state", 32'(state_a), 32'd1);
    for (int e = 1; e <= 15; e++) begin
      check("b2b_done_early", 32'(ifa.done), 32'd0);
      tick();
    end
    tick();
    check("b2b_done2", 32'(ifa.done), 32'd1);
    check("b2b_table2", 32'(ifa.table_out), 32'hE8);
    check("b2b_match2", 32'(ifa.match), 32'd1);
    ifa.start = 1'b0;
    tick();
    tick();
    check("b2b_end_idle", 32'(state_a), 32'd0);
    check("b2b_end_busy", 32'(ifa.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
